// File: rtl/blink_multi.sv
// blink_multi: multi-channel LED driver.
// A shared prescaler turns the board clock into a slow tick. Each channel is
// independently configured as off, steady on, blinking or one-shot pulse
// through a one-write-per-cycle configuration port.
// Optional feature macro: BLINK_MULTI_PWM_EN. When defined, a shared PWM
// counter and per-channel duty registers are built and brightness is applied
// to lit channels. When undefined, cfg_duty_i is ignored and a lit channel
// drives its LED fully on.

module blink_multi #(
  parameter int FREQ     = 25000000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [3:0]          cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [15:0]         cfg_period_i,
  input  logic [PWM_BITS-1:0] cfg_duty_i,
  output logic [CHANNELS-1:0] led_o,
  output logic                tick_o
);

  // Prescaler geometry: the counter runs 0..DIV-1.
  localparam int DIV   = FREQ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  // Everything a channel needs to sequence itself, kept together so that
  // loading, ticking and reset each touch one record.
  typedef struct packed {
    mode_e       mode;
    logic [15:0] period;
    logic [15:0] phase;
    logic        lit;
  } chan_t;

  // Period resets to 1 so the "phase never exceeds period-1" invariant holds
  // from the very first cycle.
  localparam chan_t CHAN_RESET = '{
    mode:   MODE_OFF,
    period: 16'd1,
    phase:  16'd0,
    lit:    1'b0
  };

  logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [CHANNELS-1:0] led_q, led_d;

  chan_t chan_q [CHANNELS];
  chan_t chan_d [CHANNELS];

  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] phase_last;
  logic [CHANNELS-1:0] lit_vec;
  logic [CHANNELS-1:0] bright;

  // Prescaler next state: wrap at DIV-1 and strobe tick for that one cycle.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally); a missed path infers a latch.
  always_comb begin
    tick_d    = (pre_cnt_q == CNT_MAX);
    pre_cnt_d = tick_d ? '0 : pre_cnt_q + 1'b1;
  end

  // Write decode: only indices below CHANNELS can match, so writes aimed at
  // absent channels fall through and change nothing.
  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_sel[c] = cfg_we_i && (cfg_ch_i == 4'(c));
    end
  end

  // Per-channel end-of-period detect, and the lit flags as a flat vector.
  always_comb begin
    phase_last = '0;
    lit_vec    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      phase_last[c] = (chan_q[c].phase == chan_q[c].period - 16'd1);
      lit_vec[c]    = chan_q[c].lit;
    end
  end

  // Channel sequencing. A write always takes priority over a tick on the
  // same channel, so a tick coinciding with a write is simply not counted
  // there. Off and on channels hold their phase counter.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      chan_d[c] = chan_q[c];
      if (wr_sel[c]) begin
        chan_d[c].mode   = mode_e'(cfg_mode_i);
        chan_d[c].period = (cfg_period_i == 16'd0) ? 16'd1 : cfg_period_i;
        chan_d[c].phase  = 16'd0;
        chan_d[c].lit    = (cfg_mode_i != MODE_OFF);
      end else if (tick_q) begin
        unique case (chan_q[c].mode)
          MODE_BLINK: begin
            if (phase_last[c]) begin
              chan_d[c].phase = 16'd0;
              chan_d[c].lit   = ~chan_q[c].lit;
            end else begin
              chan_d[c].phase = chan_q[c].phase + 16'd1;
            end
          end
          MODE_PULSE: begin
            // One-shot: park in off at the end; a new write is the only
            // way to fire again.
            if (phase_last[c]) begin
              chan_d[c].mode = MODE_OFF;
              chan_d[c].lit  = 1'b0;
            end else begin
              chan_d[c].phase = chan_q[c].phase + 16'd1;
            end
          end
          default: begin
            // Off and on ignore the tick.
          end
        endcase
      end
    end
  end

`ifdef BLINK_MULTI_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_d [CHANNELS];

  // Free-running PWM counter, duty load on write, and brightness compare.
  // Full-scale duty is forced bright so 2^PWM_BITS-1 means truly steady on.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    bright    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      duty_d[c] = wr_sel[c] ? cfg_duty_i : duty_q[c];
      bright[c] = (duty_q[c] == {PWM_BITS{1'b1}}) || (pwm_cnt_q < duty_q[c]);
    end
  end

  // PWM counter and duty storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_cnt_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        duty_q[c] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      for (int c = 0; c < CHANNELS; c++) begin
        duty_q[c] <= duty_d[c];
      end
    end
  end
`else
  // Without PWM a lit channel is always fully bright; the duty input is
  // deliberately left unused.
  logic unused_duty;
  assign unused_duty = ^cfg_duty_i;
  assign bright      = '1;
`endif

  // LED drive: lit gated by brightness, registered.
  always_comb begin
    led_d = lit_vec & bright;
  end

  // State registers: prescaler, tick strobe, LED outputs and channel state.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its pre-edge inputs regardless of statement order.
  // NOTE: the channel register array is reset element by element because a
  // reset must abort any blink or pulse in progress; this is flop storage,
  // not a RAM, so resetting it is legitimate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      led_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        chan_q[c] <= CHAN_RESET;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
      for (int c = 0; c < CHANNELS; c++) begin
        chan_q[c] <= chan_d[c];
      end
    end
  end

  assign led_o  = led_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_blink_multi.sv
// Testbench for blink_multi: FREQ=1000, TICK_HZ=100 (DIV=10), 3 channels,
// 8-bit PWM. A behavioural model computes each channel's lit state from the
// number of ticks seen since its last write (plain arithmetic), and the LED
// and tick outputs are compared every cycle. Table vectors and hand-written
// sequences cover the corner cases.

module tb_blink_multi;

  localparam int FREQ     = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = FREQ / TICK_HZ;
  localparam int CHANNELS = 3;
  localparam int PWM_BITS = 8;

`ifdef BLINK_MULTI_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                cfg_we_i = 1'b0;
  logic [3:0]          cfg_ch_i = '0;
  logic [1:0]          cfg_mode_i = '0;
  logic [15:0]         cfg_period_i = '0;
  logic [PWM_BITS-1:0] cfg_duty_i = '0;
  logic [CHANNELS-1:0] led_o;
  logic                tick_o;

  blink_multi #(
    .FREQ    (FREQ),
    .TICK_HZ (TICK_HZ),
    .CHANNELS(CHANNELS),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_period_i(cfg_period_i),
    .cfg_duty_i  (cfg_duty_i),
    .led_o       (led_o),
    .tick_o      (tick_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since reset release, and per channel the configured
  // mode/period/duty plus the number of ticks counted since the last write.
  int edges;
  int m_mode   [CHANNELS];
  int m_period [CHANNELS];
  int m_duty   [CHANNELS];
  int m_ticks  [CHANNELS];

  typedef struct {
    bit         we;
    int         ch;
    int         mode;
    int         period;
    int         duty;
    int         idle;
    logic [2:0] exp_led;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lit state from the rules: blink is lit on even half-periods, a pulse is
  // lit until `period` ticks have been counted.
  function automatic bit model_lit(input int c);
    case (m_mode[c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_ticks[c] / m_period[c]) % 2) == 0;
      default: return m_ticks[c] < m_period[c];
    endcase
  endfunction

  // Brightness uses the PWM count as seen before the coming edge.
  function automatic bit model_bright(input int c);
    if (!PWM_EN) return 1'b1;
    if (m_duty[c] == 255) return 1'b1;
    return (edges % 256) < m_duty[c];
  endfunction

  function automatic void model_clear();
    edges = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      m_mode[c]   = 0;
      m_period[c] = 1;
      m_duty[c]   = 0;
      m_ticks[c]  = 0;
    end
  endfunction

  // One clock: predict outputs after the edge, advance the model, drive the
  // inputs, take the edge and compare 1 time unit later.
  task automatic step(input bit we, input int ch, input int mode, input int period, input int duty);
    logic [2:0] exp_led;
    bit         exp_tick;
    bit         tick_now;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_led[c] = model_lit(c) & model_bright(c);
    end
    exp_tick = ((edges + 1) % DIV) == 0;
    tick_now = (edges > 0) && ((edges % DIV) == 0);
    for (int c = 0; c < CHANNELS; c++) begin
      if (we && ch == c) begin
        m_mode[c]   = mode;
        m_period[c] = (period == 0) ? 1 : period;
        m_duty[c]   = duty;
        m_ticks[c]  = 0;
      end else if (tick_now) begin
        m_ticks[c]++;
      end
    end
    edges++;
    cfg_we_i     = we;
    cfg_ch_i     = 4'(ch);
    cfg_mode_i   = 2'(mode);
    cfg_period_i = 16'(period);
    cfg_duty_i   = 8'(duty);
    @(posedge clk);
    #1;
    check("led_model", 32'(led_o), 32'(exp_led));
    check("tick_model", 32'(tick_o), 32'(exp_tick));
    cfg_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
  endtask

  // Hold reset for two edges, check reset outputs, release on a falling edge.
  task automatic do_reset();
    rst_i    = 1'b1;
    cfg_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(led_o), 32'd0);
    check("reset_tick", 32'(tick_o), 32'd0);
    model_clear();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Step idle until tick_o is seen, within a bounded number of cycles.
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      step(1'b0, 0, 0, 0, 0);
      seen = tick_o;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic count_led(input int ch, input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0, 0, 0, 0);
      highs += int'(led_o[ch]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_cnt;
    int first_tick;
    int highs;
    int toggles;
    logic prev;

    model_clear();

    // Vectors start from a fresh reset; edge numbers in the notes are the
    // edge at which led_o is compared.
    vecs[0]  = '{1'b1, 1, 2, 3, 255, 1,  3'b010}; // e2: blink lit
    vecs[1]  = '{1'b0, 0, 0, 0, 0,   28, 3'b010}; // e31: still lit
    vecs[2]  = '{1'b0, 0, 0, 0, 0,   0,  3'b000}; // e32: first toggle off
    vecs[3]  = '{1'b0, 0, 0, 0, 0,   28, 3'b000}; // e61: still off
    vecs[4]  = '{1'b0, 0, 0, 0, 0,   0,  3'b010}; // e62: back on (30 later)
    vecs[5]  = '{1'b1, 3, 1, 1, 255, 1,  3'b010}; // e64: ch3 write ignored
    vecs[6]  = '{1'b1, 2, 3, 5, 255, 1,  3'b110}; // e66: pulse lit
    vecs[7]  = '{1'b0, 0, 0, 0, 0,   24, 3'b110}; // e91
    vecs[8]  = '{1'b0, 0, 0, 0, 0,   0,  3'b100}; // e92: ch1 toggles off
    vecs[9]  = '{1'b0, 0, 0, 0, 0,   18, 3'b100}; // e111: pulse still lit
    vecs[10] = '{1'b0, 0, 0, 0, 0,   0,  3'b000}; // e112: pulse over

    // Reset and prescaler cadence: ticks on edges 10, 20, 30 only.
    do_reset();
    tick_cnt   = 0;
    first_tick = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 0, 0, 0, 0);
      if (tick_o) begin
        tick_cnt++;
        if (first_tick == 0) first_tick = i;
      end
    end
    check("tick_count_30", 32'(tick_cnt), 32'd3);
    check("tick_first_edge", 32'(first_tick), 32'd10);

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].we, vecs[i].ch, vecs[i].mode, vecs[i].period, vecs[i].duty);
      idle(vecs[i].idle);
      check($sformatf("vec%0d", i), 32'(led_o), 32'(vecs[i].exp_led));
    end

    // Brightness: duty 64, 0 and full scale over 256 cycles.
    do_reset();
    step(1'b1, 0, 1, 1, 64);
    step(1'b0, 0, 0, 0, 0);
    count_led(0, 256, highs);
    check("pwm_duty64", 32'(highs), PWM_EN ? 32'd64 : 32'd256);
    step(1'b1, 0, 1, 1, 0);
    step(1'b0, 0, 0, 0, 0);
    count_led(0, 256, highs);
    check("pwm_duty0", 32'(highs), PWM_EN ? 32'd0 : 32'd256);
    step(1'b1, 0, 1, 1, 255);
    step(1'b0, 0, 0, 0, 0);
    count_led(0, 256, highs);
    check("pwm_duty255", 32'(highs), 32'd256);

    // Blink with period 0 behaves as period 1: one toggle per tick.
    do_reset();
    step(1'b1, 1, 2, 0, 255);
    step(1'b0, 0, 0, 0, 0);
    prev    = led_o[1];
    toggles = 0;
    for (int i = 0; i < 10 * DIV; i++) begin
      step(1'b0, 0, 0, 0, 0);
      if (led_o[1] != prev) toggles++;
      prev = led_o[1];
    end
    check("blink_p0_toggles", 32'(toggles), 32'd10);

    // Write on the tick edge: ch1 loses that tick, ch0 pulse still counts it.
    do_reset();
    step(1'b1, 0, 3, 5, 255);          // e1: ch0 pulse P=5
    wait_tick("wait_tick_a");          // tick_o visible after e10
    step(1'b1, 1, 2, 3, 255);          // e11: ch1 blink P=3 on tick edge
    while (edges < 41) step(1'b0, 0, 0, 0, 0);
    check("wot_ch1_lit_e41", 32'(led_o[1]), 32'd1);
    check("wot_ch0_lit_e41", 32'(led_o[0]), 32'd1);
    step(1'b0, 0, 0, 0, 0);
    check("wot_ch1_off_e42", 32'(led_o[1]), 32'd0);
    while (edges < 51) step(1'b0, 0, 0, 0, 0);
    check("wot_ch0_lit_e51", 32'(led_o[0]), 32'd1);
    step(1'b0, 0, 0, 0, 0);
    check("wot_ch0_off_e52", 32'(led_o[0]), 32'd0);
    idle(40);
    check("wot_ch0_stays_off", 32'(led_o[0]), 32'd0);

    // Asynchronous reset between edges while an LED and the tick are high.
    do_reset();
    step(1'b1, 0, 1, 1, 255);
    wait_tick("wait_tick_b");
    check("pre_async_led", 32'(led_o[0]), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_led", 32'(led_o), 32'd0);
    check("async_tick", 32'(tick_o), 32'd0);

    // Randomised writes against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int duty_sel;
      int duty;
      duty_sel = int'($urandom_range(0, 3));
      case (duty_sel)
        0:       duty = 0;
        1:       duty = 255;
        2:       duty = 64;
        default: duty = int'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 15) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), duty);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_multi.md
# blink_multi

Multi-channel LED driver: a parametrised successor to the single-LED blinker. One shared prescaler produces a slow tick. CHANNELS independent channels are each runtime-configurable as off, steady on, blinking or one-shot pulse, with optional PWM brightness. It sits between the board clock and the LED pins and is configured by a simple write port from control logic or a soft CPU.

## Interface
- FREQ, 25000000: input clock frequency in Hz.
- TICK_HZ, 1000: prescaler tick rate in Hz; DIV = FREQ/TICK_HZ, must be >= 2.
- CHANNELS, 4: number of LED channels, 1..16.
- PWM_BITS, 8: brightness resolution in bits.
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_we_i  in  1  write strobe; one write per cycle.
- cfg_ch_i  in  4  target channel index.
- cfg_mode_i  in  2  mode: 00 off, 01 on, 10 blink, 11 pulse.
- cfg_period_i  in  16  blink half-period or pulse length, in ticks.
- cfg_duty_i  in  PWM_BITS  brightness while lit.
- led_o  out  CHANNELS  LED drive, one bit per channel, registered.
- tick_o  out  1  one-cycle prescaler tick strobe, registered.

## Operation
- Prescaler: counter 0..DIV-1, width $clog2(DIV). When it reaches DIV-1 it wraps to 0 and tick_o is high for exactly that one cycle.
- Per-channel state:
  - mode (2b)
  - period (16b; a write of 0 is stored as 1)
  - duty
  - phase counter (16b)
  - lit flag
- Write with cfg_ch_i < CHANNELS loads mode, period and duty, clears the phase counter and sets lit = (mode != off).
- Write with cfg_ch_i >= CHANNELS is ignored entirely.
- Mode off: lit = 0; the phase counter is held.
- Mode on: lit = 1; the phase counter is held.
- Mode blink: on each tick, if phase == period-1 then phase <= 0 and lit toggles; otherwise phase increments.
- Mode pulse: on each tick, if phase == period-1 then mode <= off and lit <= 0; otherwise phase increments. The pulse does not retrigger by itself.
- PWM counter: free-running PWM_BITS bits, incrementing every clk_i cycle, shared by all channels.
- Output rule: led_o[n] <= lit[n] & bright[n].
  - bright = 1 when duty == 2^PWM_BITS-1 (full scale).
  - Otherwise bright = (pwm_cnt < duty).
  - duty == 0 is always dark.

## Timing
- Reset values (asynchronous on rst_i):
  - led_o = 0, tick_o = 0.
  - Prescaler, PWM counter and all phase counters = 0.
  - All modes off, all lit = 0.
  - Reset mid-pulse or mid-blink aborts immediately; no state survives.
- First tick_o after reset release: DIV rising edges later.
- Write latency: a write sampled on edge E updates channel state on E; led_o reflects it on edge E+1.
- Write and tick on the same edge, same channel: the write wins and the tick is not counted for that channel. Other channels count the tick normally.
- Tick counting: the first tick after a write counts, so a pulse of period P lasts between (P-1)*DIV+1 and P*DIV cycles of lit. The blink half-period is exactly P*DIV cycles after the first toggle.
- Phase counter never exceeds period-1. Rewriting a smaller period always clears phase, so no wrap-around hazard exists.

## Configuration
- Macro BLINK_MULTI_PWM_EN.
- Defined: the PWM counter and the per-channel duty registers are built, and brightness is applied as above.
- Undefined: no PWM counter and no duty storage. cfg_duty_i is ignored and led_o[n] <= lit[n].

## Test plan
Benches use FREQ=1000, TICK_HZ=100 (DIV=10), CHANNELS=3, PWM_BITS=8.
- Reset, then release: tick_o high on cycle 10, 20, 30 only. Assert rst_i mid-cycle: led_o and tick_o go 0 without a clock edge.
- Write ch1 blink, period=3, duty=255: led_o[1] high one cycle after the write, then toggles every 30 cycles from the first toggle. Channels 0 and 2 stay 0.
- Write ch2 pulse, period=5, duty=255: led_o[2] high for 41..50 cycles, then 0 permanently until the next write.
- Write ch0 on, duty=64: led_o[0] high exactly 64 of every 256 cycles. duty=0 gives always 0; duty=255 gives always 1. With BLINK_MULTI_PWM_EN undefined, duty=64 gives always 1.
- Write with cfg_ch_i=3: no channel changes. Write ch1 with period=0 in blink: toggles every tick (period treated as 1).
- Write ch1 blink on the edge where tick_o is high: ch1 phase=0 afterwards and its first toggle lands 3 ticks later. A ch0 pulse in progress still advances on that tick.
